// File: rtl/checkpoint_reg.sv
// checkpoint_reg: register with a bounded LIFO of save/restore checkpoints
// Ports: CLK clock, RST sync active-high reset, D_IN/EN write, SAVE push Q_OUT,
//        REVERT pop into Q_OUT (init when empty), Q_OUT value, COUNT checkpoints,
//        EMPTY/FULL decoded from COUNT, ERR overflow/underflow indication.
// Macro CHECKPOINT_REG_STICKY_ERR_EN: ERR sticks until RST; otherwise 1-cycle pulse.
module checkpoint_reg #(
  parameter int width = 1,
  parameter logic [width-1:0] init = '0,
  parameter int depth = 4,
  parameter int cnt_width = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [width-1:0]     D_IN,
  input  logic                 EN,
  input  logic                 SAVE,
  input  logic                 REVERT,
  output logic [width-1:0]     Q_OUT,
  output logic [cnt_width-1:0] COUNT,
  output logic                 EMPTY,
  output logic                 FULL,
  output logic                 ERR
);
  localparam int aw = depth > 1 ? $clog2(depth) : 1;
  logic [width-1:0] stack [2**aw];
  logic [aw-1:0] wr_idx, rd_idx;
  logic push, pop, err_ev;
  assign EMPTY = COUNT == '0;
  assign FULL = COUNT == cnt_width'(depth);
  assign wr_idx = aw'(COUNT);
  assign rd_idx = aw'(COUNT - 1'b1);
  assign pop = REVERT & ~EMPTY;
  assign push = SAVE & ~REVERT & ~FULL;
  assign err_ev = (REVERT & EMPTY) | (SAVE & ~REVERT & FULL);
  always_ff @(posedge CLK) begin
    if (push) stack[wr_idx] <= Q_OUT;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      Q_OUT <= init;
      COUNT <= '0;
      ERR <= 1'b0;
    end else begin
      Q_OUT <= REVERT ? (EMPTY ? init : stack[rd_idx]) : EN ? D_IN : Q_OUT;
      COUNT <= pop ? COUNT - 1'b1 : push ? COUNT + 1'b1 : COUNT;
`ifdef CHECKPOINT_REG_STICKY_ERR_EN
      ERR <= ERR | err_ev;
`else
      ERR <= err_ev;
`endif
    end
  end
endmodule

// File: tb/tb_checkpoint_reg.sv
// tb_checkpoint_reg: randomized + directed scoreboard bench for checkpoint_reg
module tb_checkpoint_reg;
  localparam logic [7:0] init_v = 8'hA5;
  localparam int depth_v = 4;
  logic clk = 0, rst = 0, en = 0, save = 0, revert = 0;
  logic [7:0] d_in = 0, q_out;
  logic [2:0] count;
  logic empty, full, err;
  typedef struct {
    logic [7:0] q;
    logic [2:0] cnt;
    logic empty, full, err;
  } exp_t;
  exp_t sb[$];
  logic [7:0] hist[$];
  logic [7:0] m_q = init_v;
  logic m_err = 0;
  int n_cmp = 0, n_bad = 0;
  checkpoint_reg #(.width(8), .init(init_v), .depth(depth_v), .cnt_width(3)) dut (
    .CLK(clk), .RST(rst), .D_IN(d_in), .EN(en), .SAVE(save), .REVERT(revert),
    .Q_OUT(q_out), .COUNT(count), .EMPTY(empty), .FULL(full), .ERR(err)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [7:0] act, logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("q_out", q_out, e.q);
      chk("count", {5'd0, count}, {5'd0, e.cnt});
      chk("empty", {7'd0, empty}, {7'd0, e.empty});
      chk("full", {7'd0, full}, {7'd0, e.full});
      chk("err", {7'd0, err}, {7'd0, e.err});
    end
  end
  task automatic step(input logic r, input logic e, input logic [7:0] d, input logic s, input logic v);
    logic ev;
    exp_t x;
    rst = r; en = e; d_in = d; save = s; revert = v;
    @(posedge clk);
    ev = 0;
    if (r) begin
      m_q = init_v;
      hist.delete();
      m_err = 0;
    end else begin
      if (v) begin
        if (hist.size() > 0) m_q = hist.pop_back();
        else begin m_q = init_v; ev = 1; end
      end else begin
        if (s) begin
          if (hist.size() < depth_v) hist.push_back(m_q);
          else ev = 1;
        end
        if (e) m_q = d;
      end
`ifdef CHECKPOINT_REG_STICKY_ERR_EN
      m_err = m_err | ev;
`else
      m_err = ev;
`endif
    end
    x.q = m_q;
    x.cnt = 3'(hist.size());
    x.empty = hist.size() == 0;
    x.full = hist.size() == depth_v;
    x.err = m_err;
    sb.push_back(x);
    #1;
  endtask
  initial begin
    step(1, 0, 0, 0, 0);
    step(0, 1, 8'h3C, 0, 0);
    step(0, 1, 8'h11, 0, 0);
    step(0, 1, 8'h22, 1, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 8'(i), 0, 0);
      step(0, 0, 0, 1, 0);
    end
    step(0, 1, 8'h05, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    step(0, 1, 8'h77, 0, 0);
    step(0, 1, 8'h99, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 8'h0F, 1, 0);
    step(0, 1, 8'h10, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 8'hFF, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++)
      step($urandom_range(39) == 0, $urandom_range(1) == 1, 8'($urandom),
           $urandom_range(2) == 0, $urandom_range(3) == 0);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
